bridge_uart_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single UART bridge Avalon-MM slave between two masters:
//   m0 = UART/FIFO monitor, m1 = host register access.

---
 rtl/bridge_uart_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bridge_uart_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_uart_arbiter.sv
// Round-robin arbiter sharing the UART bridge Avalon-MM slave between the UART/FIFO
// monitor (m0) and host register access (m1); every transfer is bounded by an ack timeout.
module bridge_uart_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byte_enable,
  input  logic [5:0]  m0_address,
  input  logic [31:0] m0_write_data,
  output logic        m0_acknowledge,
  output logic [31:0] m0_read_data,
  output logic        m0_timeout,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byte_enable,
  input  logic [5:0]  m1_address,
  input  logic [31:0] m1_write_data,
  output logic        m1_acknowledge,
  output logic [31:0] m1_read_data,
  output logic        m1_timeout,
  output logic        bridge_uart_read,
  output logic        bridge_uart_write,
  output logic [3:0]  bridge_uart_byte_enable,
  output logic [5:0]  bridge_uart_address,
  output logic [31:0] bridge_uart_write_data,
  input  logic        bridge_uart_acknowledge,
  input  logic [31:0] bridge_uart_read_data,
  output logic [1:0]  grant,
  output logic [15:0] timeout_count
);
  // state   | meaning
  // IDLE    | no owner; requests sampled every edge
  // BUSY    | transfer presented to slave; waiting for ack or timeout
  // RELEASE | owner has its ack; one dead cycle so it can drop its strobe
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             bu_read_q, bu_read_d;
  logic             bu_write_q, bu_write_d;
  logic [3:0]       bu_be_q, bu_be_d;
  logic [5:0]       bu_addr_q, bu_addr_d;
  logic [31:0]      bu_wdata_q, bu_wdata_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       tmo_q, tmo_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;
  logic [15:0]      tcount_q, tcount_d;

  logic [1:0]  req;
  logic        win1;
  logic        sel_read;
  logic        sel_write;
  logic [3:0]  sel_be;
  logic [5:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        done;
  logic        timed_out;
  logic [31:0] ret_data;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      bu_read_q  <= 1'b0;
      bu_write_q <= 1'b0;
      bu_be_q    <= 4'h0;
      bu_addr_q  <= 6'h00;
      bu_wdata_q <= 32'h0;
      ack_q      <= 2'b00;
      tmo_q      <= 2'b00;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
      tcount_q   <= 16'h0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      bu_read_q  <= bu_read_d;
      bu_write_q <= bu_write_d;
      bu_be_q    <= bu_be_d;
      bu_addr_q  <= bu_addr_d;
      bu_wdata_q <= bu_wdata_d;
      ack_q      <= ack_d;
      tmo_q      <= tmo_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      tcount_q   <= tcount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    bu_read_d  = bu_read_q;
    bu_write_d = bu_write_q;
    bu_be_d    = bu_be_q;
    bu_addr_d  = bu_addr_q;
    bu_wdata_d = bu_wdata_q;
    ack_d      = 2'b00;
    tmo_d      = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    tcount_d   = tcount_q;

    req       = {m1_read | m1_write, m0_read | m0_write};
    // m1 wins when alone, or when both request and the pointer favours it
    win1      = req[1] & (~req[0] | rr_q);
    sel_read  = win1 ? m1_read        : m0_read;
    sel_write = win1 ? m1_write       : m0_write;
    sel_be    = win1 ? m1_byte_enable : m0_byte_enable;
    sel_addr  = win1 ? m1_address     : m0_address;
    sel_wdata = win1 ? m1_write_data  : m0_write_data;

    // a slave ack on the terminal-count cycle still counts as a normal completion
    done      = bridge_uart_acknowledge | (cnt_q == '0);
    timed_out = ~bridge_uart_acknowledge;
    ret_data  = timed_out ? TIMEOUT_DATA : bridge_uart_read_data;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d    = win1;
          rr_d       = ~win1;
          grant_d    = win1 ? 2'b10 : 2'b01;
          bu_read_d  = sel_read;
          bu_write_d = sel_write & ~sel_read;
          bu_be_d    = sel_be;
          bu_addr_d  = sel_addr;
          bu_wdata_d = sel_wdata;
          cnt_d      = CNT_LOAD;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          bu_read_d       = 1'b0;
          bu_write_d      = 1'b0;
          bu_be_d         = 4'h0;
          ack_d[owner_q]  = 1'b1;
          tmo_d[owner_q]  = timed_out;
          if (bu_read_q) begin
            if (owner_q) rdata1_d = ret_data;
            else         rdata0_d = ret_data;
          end
          if (timed_out && (tcount_q != 16'hFFFF)) tcount_d = tcount_q + 16'd1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_acknowledge          = ack_q[0];
  assign m1_acknowledge          = ack_q[1];
  assign m0_timeout              = tmo_q[0];
  assign m1_timeout              = tmo_q[1];
  assign m0_read_data            = rdata0_q;
  assign m1_read_data            = rdata1_q;
  assign bridge_uart_read        = bu_read_q;
  assign bridge_uart_write       = bu_write_q;
  assign bridge_uart_byte_enable = bu_be_q;
  assign bridge_uart_address     = bu_addr_q;
  assign bridge_uart_write_data  = bu_wdata_q;
  assign grant                   = grant_q;
  assign timeout_count           = tcount_q;

endmodule

// File: tb/tb_bridge_uart_arbiter.sv
// Bench for bridge_uart_arbiter: directed scenarios, then random traffic checked
// against a transaction-timeline reference model.
module tb_bridge_uart_arbiter;
  localparam int TC = 16;
  localparam logic [31:0] TDATA = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        nreset;
  logic [1:0]  mrd, mwr;
  logic [3:0]  mbe  [2];
  logic [5:0]  madr [2];
  logic [31:0] mwd  [2];
  logic [1:0]  mack, mto;
  logic [31:0] m0_read_data, m1_read_data;
  logic        bu_read, bu_write, bu_ack;
  logic [3:0]  bu_be;
  logic [5:0]  bu_adr;
  logic [31:0] bu_wd, bu_rd;
  logic [1:0]  grant;
  logic [15:0] timeout_count;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model state: one outstanding transfer described by its edge numbers
  int          prio, owner, start, done, lat, free_edge;
  bit          busy, tmo, e_rd, e_wr;
  logic [3:0]  e_be;
  logic [5:0]  e_adr;
  logic [31:0] e_wd, sdata;
  logic [31:0] exp_rd [2];
  logic [15:0] exp_tc;

  bridge_uart_arbiter #(.TIMEOUT_CYCLES(TC), .TIMEOUT_DATA(TDATA)) dut (
    .clock(clock),
    .nreset(nreset),
    .m0_read(mrd[0]),
    .m0_write(mwr[0]),
    .m0_byte_enable(mbe[0]),
    .m0_address(madr[0]),
    .m0_write_data(mwd[0]),
    .m0_acknowledge(mack[0]),
    .m0_read_data(m0_read_data),
    .m0_timeout(mto[0]),
    .m1_read(mrd[1]),
    .m1_write(mwr[1]),
    .m1_byte_enable(mbe[1]),
    .m1_address(madr[1]),
    .m1_write_data(mwd[1]),
    .m1_acknowledge(mack[1]),
    .m1_read_data(m1_read_data),
    .m1_timeout(mto[1]),
    .bridge_uart_read(bu_read),
    .bridge_uart_write(bu_write),
    .bridge_uart_byte_enable(bu_be),
    .bridge_uart_address(bu_adr),
    .bridge_uart_write_data(bu_wd),
    .bridge_uart_acknowledge(bu_ack),
    .bridge_uart_read_data(bu_rd),
    .grant(grant),
    .timeout_count(timeout_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] rdata(input int n);
    return n ? m1_read_data : m0_read_data;
  endfunction

  function automatic logic [1:0] oh(input int n);
    return n ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    for (int n = 0; n < 2; n++) begin
      mrd[n] = 1'b0; mwr[n] = 1'b0; mbe[n] = 4'h0; madr[n] = 6'h0; mwd[n] = 32'h0;
    end
    bu_ack = 1'b0;
    bu_rd  = 32'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_bu_strobes"}, {bu_read, bu_write}, 2'b00);
    chk({tag, "_bu_be"}, bu_be, 4'h0);
    chk({tag, "_bu_addr"}, bu_adr, 6'h0);
    chk({tag, "_bu_wdata"}, bu_wd, 32'h0);
    chk({tag, "_ack_tmo"}, {mack, mto}, 4'h0);
    chk({tag, "_rdata0"}, m0_read_data, 32'h0);
    chk({tag, "_rdata1"}, m1_read_data, 32'h0);
    chk({tag, "_tcount"}, timeout_count, 16'h0);
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    nreset = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    nreset = 1'b1;
  endtask

  task automatic model_init();
    busy = 0; tmo = 0; prio = 0; owner = 0; start = 0; done = 0; lat = 0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; exp_tc = 16'h0;
    free_edge = cyc + 1;
  endtask

  task automatic new_req(input int n);
    int r;
    r = $urandom_range(0, 3);
    mrd[n]  = (r != 2);
    mwr[n]  = (r >= 2);
    mbe[n]  = 4'($urandom);
    madr[n] = 6'($urandom);
    mwd[n]  = $urandom;
  endtask

  task automatic run_random(input int ncyc, input bit cont);
    for (int k = 0; k < ncyc; k++) begin
      logic [1:0] act;
      bit xfer, done_now;
      @(negedge clock);
      act = mrd | mwr;
      if (!busy && cyc >= free_edge && act != 2'b00) begin
        int w, r;
        w = (act == 2'b11) ? prio : (act[1] ? 1 : 0);
        prio  = 1 - w;
        busy  = 1;
        owner = w;
        start = cyc;
        e_rd  = mrd[w];
        e_wr  = mwr[w] & ~mrd[w];
        e_be  = mbe[w];
        e_adr = madr[w];
        e_wd  = mwd[w];
        sdata = $urandom;
        r = $urandom_range(0, 9);
        tmo = (r >= 8);
        lat = (r <= 5) ? (r % 4) : TC - 1;
        done = tmo ? start + TC : start + lat + 1;
      end
      done_now = busy && (cyc == done);
      if (done_now) begin
        if (e_rd) exp_rd[owner] = tmo ? TDATA : sdata;
        if (tmo && exp_tc != 16'hFFFF) exp_tc = exp_tc + 16'd1;
      end
      xfer = busy && (cyc < done);
      chk("grant", grant, busy ? oh(owner) : 2'b00);
      chk("bu_read", bu_read, xfer && e_rd);
      chk("bu_write", bu_write, xfer && e_wr);
      chk("bu_be", bu_be, xfer ? e_be : 4'h0);
      if (xfer) begin
        chk("bu_addr", bu_adr, e_adr);
        chk("bu_wdata", bu_wd, e_wd);
      end
      for (int n = 0; n < 2; n++) begin
        chk("m_ack", mack[n], done_now && owner == n);
        chk("m_timeout", mto[n], done_now && tmo && owner == n);
        chk("m_rdata", rdata(n), exp_rd[n]);
      end
      chk("tcount", timeout_count, exp_tc);
      if (done_now) begin
        busy = 0;
        free_edge = done + 2;
      end
      bu_ack = busy && !tmo && (cyc == start + lat);
      bu_rd  = bu_ack ? sdata : $urandom;
      for (int n = 0; n < 2; n++) begin
        if (done_now && n == owner) begin
          if (cont || $urandom_range(0, 1) == 1) new_req(n);
          else begin mrd[n] = 1'b0; mwr[n] = 1'b0; end
        end else if (busy && n == owner) begin
          // owner inputs must be ignored while its transfer is in flight
          if ($urandom_range(0, 3) == 0) begin
            madr[n] = 6'($urandom); mwd[n] = $urandom; mbe[n] = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin mrd[n] = 1'b0; mwr[n] = 1'b0; end
          end
        end else if ((mrd[n] | mwr[n]) == 1'b0 && (cont || $urandom_range(0, 3) == 0)) begin
          new_req(n);
        end
      end
    end
  endtask

  initial begin
    nreset = 1'b0;
    clear_inputs();
    do_reset();

    // single m0 read, slave answers three cycles after the strobe appears
    mrd[0] = 1'b1; madr[0] = 6'h28; mbe[0] = 4'hF;
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_read", bu_read, 1'b1);
    chk("t1_addr", bu_adr, 6'h28);
    tick();
    tick();
    bu_ack = 1'b1; bu_rd = 32'h0000_0080;
    tick();
    chk("t1_ack", mack, 2'b01);
    chk("t1_rdata", m0_read_data, 32'h80);
    chk("t1_strobe_drop", {bu_read, bu_be}, 5'h0);
    bu_ack = 1'b0; mrd[0] = 1'b0;
    tick();
    chk("t1_ack_pulse", mack, 2'b00);
    chk("t1_release", grant, 2'b00);

    // simultaneous m0 read and m1 write right after reset
    do_reset();
    mrd[0] = 1'b1; madr[0] = 6'h01;
    mwr[1] = 1'b1; madr[1] = 6'h10; mwd[1] = 32'h1234_5678; mbe[1] = 4'hF;
    tick();
    chk("t2_grant0", grant, 2'b01);
    chk("t2_read", bu_read, 1'b1);
    bu_ack = 1'b1; bu_rd = 32'h0000_0011;
    tick();
    chk("t2_ack0", mack, 2'b01);
    bu_ack = 1'b0; mrd[0] = 1'b0;
    tick();
    tick();
    chk("t2_grant1", grant, 2'b10);
    chk("t2_write", {bu_read, bu_write}, 2'b01);
    chk("t2_wdata", bu_wd, 32'h1234_5678);
    chk("t2_addr", bu_adr, 6'h10);
    bu_ack = 1'b1; bu_rd = 32'hCAFE_0000;
    tick();
    chk("t2_ack1", mack, 2'b10);
    chk("t2_wr_rdata", m1_read_data, 32'h0);
    chk("t2_hold0", m0_read_data, 32'h11);
    bu_ack = 1'b0; mwr[1] = 1'b0;
    tick();
    tick();

    // m1 read that the slave never answers, m0 waiting behind it
    do_reset();
    mrd[1] = 1'b1; madr[1] = 6'h05;
    tick();
    chk("t4_grant1", grant, 2'b10);
    mrd[0] = 1'b1; madr[0] = 6'h33;
    for (int i = 1; i < TC; i++) begin
      tick();
      chk("t4_no_ack_early", {mack, mto}, 4'h0);
    end
    tick();
    chk("t4_ack_tmo", {mack, mto}, 4'b1010);
    chk("t4_rdata", m1_read_data, TDATA);
    chk("t4_tcount", timeout_count, 16'd1);
    mrd[1] = 1'b0;
    tick();
    chk("t4_release", grant, 2'b00);
    tick();
    chk("t4_grant0", grant, 2'b01);
    chk("t4_addr0", bu_adr, 6'h33);
    bu_ack = 1'b1; bu_rd = 32'h0000_00A5;
    tick();
    chk("t4_ack0", {mack, mto}, 4'b0100);
    chk("t4_rdata0", m0_read_data, 32'hA5);
    bu_ack = 1'b0; mrd[0] = 1'b0;
    tick();
    tick();

    // reset pulse while a transfer is in flight
    mrd[1] = 1'b1; madr[1] = 6'h07; mbe[1] = 4'h3;
    tick();
    chk("t5_grant", grant, 2'b10);
    nreset = 1'b0;
    tick();
    chk_all_zero("t5_midreset");
    nreset = 1'b1;
    tick();
    chk("t5_regrant", grant, 2'b10);
    chk("t5_read", bu_read, 1'b1);
    chk("t5_addr", bu_adr, 6'h07);
    bu_ack = 1'b1; bu_rd = 32'h0000_0055;
    tick();
    chk("t5_ack", mack, 2'b10);
    chk("t5_rdata", m1_read_data, 32'h55);
    bu_ack = 1'b0; mrd[1] = 1'b0;
    tick();
    tick();

    // read and write strobes together: read wins, single ack
    mrd[0] = 1'b1; mwr[0] = 1'b1; madr[0] = 6'h2A;
    tick();
    chk("t6_strobes", {bu_read, bu_write}, 2'b10);
    bu_ack = 1'b1; bu_rd = 32'h0000_0F0F;
    tick();
    chk("t6_ack", mack, 2'b01);
    bu_ack = 1'b0; mrd[0] = 1'b0; mwr[0] = 1'b0;
    tick();
    chk("t6_single_ack", mack, 2'b00);
    tick();

    do_reset();
    model_init();
    run_random(1500, 1'b0);

    do_reset();
    model_init();
    run_random(400, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
